// File: rtl/dvi_rx_timing_monitor.sv
// DVI receive-side timing monitor: decodes vs/hs/de/RGB into coordinates, strobes, measured size and lock.
// Optional macro PATTERN_CHECK_EN adds per-pixel colour comparison (pix_mismatch, mismatch_cnt).
module dvi_rx_timing_monitor #(
  parameter int unsigned      CNT_W       = 16,
  parameter logic [CNT_W-1:0] HS_CNT_MAX  = 16'd1920,
  parameter logic [CNT_W-1:0] VS_CNT_MAX  = 16'd1080,
  parameter int unsigned      LOCK_FRAMES = 2
`ifdef PATTERN_CHECK_EN
  ,
  parameter logic [7:0]       EXP_R       = 8'd255,
  parameter logic [7:0]       EXP_G       = 8'd255,
  parameter logic [7:0]       EXP_B       = 8'd255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             hs,
  input  logic             de,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic             frame_start,
  output logic             frame_end,
  output logic             line_end,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             fmt_err
`ifdef PATTERN_CHECK_EN
  ,
  output logic             pix_mismatch,
  output logic [2*CNT_W-1:0] mismatch_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_VS,
    WAIT_LINE,
    IN_LINE,
    FRAME_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ALL1   = '1;
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

  state_t           state;
  logic             vs1, hs1, de1;
  logic [7:0]       r1, g1, b1;
  logic             vs_d, de_d;

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] first_cnt;
  logic             first_done;
  logic             frame_bad;
  logic [3:0]       lock_cnt;

  logic             vs_rise, vs_fall, de_rise;
  logic             in_frame, close_line, frame_close;
  logic             line_first, pix_next, pixel;
  logic             x_sat, y_sat, cnt_bad, mm;
  logic             bad_nx, frame_bad_final;
  logic [CNT_W-1:0] line_cnt_nx;
  logic [3:0]       lock_inc;

  // History registers reset high so a frame already running at reset release
  // produces no rising edge on vs or de.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs1  <= 1'b1;
      de1  <= 1'b1;
      hs1  <= 1'b0;
      r1   <= '0;
      g1   <= '0;
      b1   <= '0;
      vs_d <= 1'b1;
      de_d <= 1'b1;
    end else begin
      vs1  <= vs;
      de1  <= de;
      hs1  <= hs;
      r1   <= red;
      g1   <= green;
      b1   <= blue;
      vs_d <= vs1;
      de_d <= de1;
    end
  end

  always_comb begin
    vs_rise     = vs1 & ~vs_d;
    vs_fall     = ~vs1 & vs_d;
    de_rise     = de1 & ~de_d;
    in_frame    = (state == WAIT_LINE) || (state == IN_LINE);
    close_line  = (state == IN_LINE) && (!de1 || vs_fall);
    frame_close = in_frame && vs_fall;
    line_first  = (state == WAIT_LINE) && !vs_fall && de_rise;
    pix_next    = (state == IN_LINE) && !close_line;
    pixel       = line_first || pix_next;
    x_sat       = pix_next && (pix_x == ALL1);
    cnt_bad     = (pix_cnt != HS_CNT_MAX) || (first_done && (pix_cnt != first_cnt));

    line_cnt_nx = line_cnt;
    y_sat       = 1'b0;
    if (close_line) begin
      if (line_cnt == ALL1) y_sat = 1'b1;
      else                  line_cnt_nx = line_cnt + 1'b1;
    end

    mm = 1'b0;
`ifdef PATTERN_CHECK_EN
    mm = pixel && ({r1, g1, b1} != {EXP_R, EXP_G, EXP_B});
`endif

    bad_nx = frame_bad | (in_frame && (hs1 != de1)) | (close_line && cnt_bad)
           | x_sat | y_sat | mm;
    frame_bad_final = bad_nx | (line_cnt_nx != VS_CNT_MAX);
    lock_inc = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + 4'd1;
  end

  // The frame close (including a line cut short by vs) is resolved in the cycle
  // the vs fall is seen, so its outputs are visible while the FSM sits in FRAME_DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_VS;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_end    <= 1'b0;
      h_active    <= '0;
      v_active    <= '0;
      locked      <= 1'b0;
      fmt_err     <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      first_cnt   <= '0;
      first_done  <= 1'b0;
      frame_bad   <= 1'b0;
      lock_cnt    <= '0;
`ifdef PATTERN_CHECK_EN
      pix_mismatch <= 1'b0;
      mismatch_cnt <= '0;
`endif
    end else begin
      pix_valid   <= pixel;
      pix_r       <= r1;
      pix_g       <= g1;
      pix_b       <= b1;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_end    <= 1'b0;
      fmt_err     <= 1'b0;
`ifdef PATTERN_CHECK_EN
      pix_mismatch <= mm;
      if (mm && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + 1'b1;
`endif

      if (line_first) begin
        pix_x   <= '0;
        pix_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (pix_next) begin
        if (!x_sat)          pix_x   <= pix_x + 1'b1;
        if (pix_cnt != ALL1) pix_cnt <= pix_cnt + 1'b1;
      end

      if (close_line) begin
        line_end <= 1'b1;
        h_active <= pix_cnt;
        line_cnt <= line_cnt_nx;
        pix_y    <= pix_y + 1'b1;
        if (!first_done) begin
          first_done <= 1'b1;
          first_cnt  <= pix_cnt;
        end
      end

      if (in_frame) frame_bad <= bad_nx;

      if (frame_close) begin
        frame_end <= 1'b1;
        v_active  <= line_cnt_nx;
        fmt_err   <= frame_bad_final;
        if (frame_bad_final) begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end else begin
          lock_cnt <= lock_inc;
          locked   <= (lock_inc == LOCK_N);
        end
      end

      case (state)
        WAIT_VS, FRAME_DONE: begin
          state <= WAIT_VS;
          if (vs_rise) begin
            frame_start <= 1'b1;
            pix_y       <= '0;
            line_cnt    <= '0;
            frame_bad   <= 1'b0;
            first_done  <= 1'b0;
            state       <= WAIT_LINE;
`ifdef PATTERN_CHECK_EN
            mismatch_cnt <= '0;
`endif
          end
        end
        WAIT_LINE: begin
          if (vs_fall)      state <= FRAME_DONE;
          else if (de_rise) state <= IN_LINE;
        end
        IN_LINE: begin
          if (vs_fall)   state <= FRAME_DONE;
          else if (!de1) state <= WAIT_LINE;
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_dvi_rx_timing_monitor.sv
// Directed bench for dvi_rx_timing_monitor on a reduced 16x6 raster.
module tb_dvi_rx_timing_monitor;

  localparam int HS = 16;
  localparam int VS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [7:0]  red = 8'd255, green = 8'd255, blue = 8'd255;
  logic        pix_valid, frame_start, frame_end, line_end, locked, fmt_err;
  logic [15:0] pix_x, pix_y, h_active, v_active;
  logic [7:0]  pix_r, pix_g, pix_b;
`ifdef PATTERN_CHECK_EN
  logic        pix_mismatch;
  logic [31:0] mismatch_cnt;
`endif

  dvi_rx_timing_monitor #(
    .CNT_W(16),
    .HS_CNT_MAX(16'd16),
    .VS_CNT_MAX(16'd6),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .vs(vs), .hs(hs), .de(de),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
    .h_active(h_active), .v_active(v_active), .locked(locked), .fmt_err(fmt_err)
`ifdef PATTERN_CHECK_EN
    , .pix_mismatch(pix_mismatch), .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  // Pulse counters, independent coordinate model and frame_end snapshots.
  int fs_cnt = 0, fe_cnt = 0, le_cnt = 0, pv_cnt = 0, ferr_cnt = 0;
  int coord_err = 0, data_err = 0, ex = 0, ey = 0;
  logic [15:0] cap_h = '0, cap_v = '0;
  logic cap_err = 1'b0, cap_lock = 1'b0, cap_le = 1'b0;
  int mm_cnt = 0;
  logic [15:0] mm_x = '0, mm_y = '0;
  int inj_en = 0, inj_x = 0, inj_y = 0;

  always @(negedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (line_end)    le_cnt <= le_cnt + 1;
    if (fmt_err)     ferr_cnt <= ferr_cnt + 1;
    if (frame_end) begin
      fe_cnt   <= fe_cnt + 1;
      cap_h    <= h_active;
      cap_v    <= v_active;
      cap_err  <= fmt_err;
      cap_lock <= locked;
      cap_le   <= line_end;
    end
    if (pix_valid) begin
      pv_cnt <= pv_cnt + 1;
      if (pix_x !== 16'(ex) || pix_y !== 16'(ey)) coord_err <= coord_err + 1;
      if (pix_g !== 8'd255 || pix_b !== 8'd255) data_err <= data_err + 1;
      ex <= ex + 1;
    end
    if (line_end) begin
      ex <= 0;
      ey <= ey + 1;
    end
    if (frame_start) begin
      ex <= 0;
      ey <= 0;
    end
`ifdef PATTERN_CHECK_EN
    if (pix_mismatch) begin
      mm_cnt <= mm_cnt + 1;
      mm_x   <= pix_x;
      mm_y   <= pix_y;
    end
`endif
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_line(input int y, input int n);
    for (int x = 0; x < n; x++) begin
      de  = 1'b1;
      hs  = 1'b1;
      red = (inj_en != 0 && x == inj_x && y == inj_y) ? 8'h00 : 8'hFF;
      @(negedge clk);
    end
  endtask

  task automatic gap(input int n);
    de  = 1'b0;
    hs  = 1'b0;
    red = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int short_len,
                            input int abort_line, input int abort_pix);
    int n;
    vs = 1'b1;
    gap(3);
    for (int y = 0; y < nlines; y++) begin
      n = (y == short_line) ? short_len : HS;
      if (y == abort_line) n = abort_pix;
      send_line(y, n);
      if (y == abort_line) break;
      gap(4);
    end
    vs = 1'b0;
    gap(8);
  endtask

  int b_fs, b_fe, b_le, b_pv, b_fer;

  task automatic snap();
    b_fs = fs_cnt; b_fe = fe_cnt; b_le = le_cnt; b_pv = pv_cnt; b_fer = ferr_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_h_active", h_active, 0);
    chk("rst_v_active", v_active, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_start", frame_start, 0);
    rst = 1'b1;
    gap(4);

    // Three good frames: measurement, strobes, lock after second frame_end
    snap();
    send_frame(VS, -1, 0, -1, 0);
    chk("f1_h_active", cap_h, HS);
    chk("f1_v_active", cap_v, VS);
    chk("f1_fmt_err", cap_err, 0);
    chk("f1_locked", cap_lock, 0);
    send_frame(VS, -1, 0, -1, 0);
    chk("f2_locked", cap_lock, 1);
    chk("f2_fmt_err", cap_err, 0);
    send_frame(VS, -1, 0, -1, 0);
    chk("f3_locked", cap_lock, 1);
    chk("t1_frame_starts", fs_cnt - b_fs, 3);
    chk("t1_frame_ends", fe_cnt - b_fe, 3);
    chk("t1_line_ends", le_cnt - b_le, 3 * VS);
    chk("t1_pixels", pv_cnt - b_pv, 3 * VS * HS);
    chk("t1_fmt_err_pulses", ferr_cnt - b_fer, 0);

    // One short line breaks lock; two good frames re-lock
    send_frame(VS, 2, HS - 1, -1, 0);
    chk("t2_fmt_err", cap_err, 1);
    chk("t2_locked_drop", cap_lock, 0);
    send_frame(VS, -1, 0, -1, 0);
    chk("t2_relock_1", cap_lock, 0);
    chk("t2_good_err", cap_err, 0);
    send_frame(VS, -1, 0, -1, 0);
    chk("t2_relock_2", cap_lock, 1);

    // Frame one line short, then de activity with vs low
    send_frame(VS - 1, -1, 0, -1, 0);
    chk("t3_v_active", cap_v, VS - 1);
    chk("t3_fmt_err", cap_err, 1);
    chk("t3_locked", cap_lock, 0);
    snap();
    for (int k = 0; k < 3; k++) begin
      send_line(0, HS);
      gap(4);
    end
    gap(4);
    chk("t3_vslow_pixels", pv_cnt - b_pv, 0);
    chk("t3_vslow_line_ends", le_cnt - b_le, 0);
    chk("t3_vslow_frame_starts", fs_cnt - b_fs, 0);

    // vs drops mid-line after 10 pixels of line 2
    send_frame(VS, -1, 0, 2, 10);
    chk("t4_h_active", cap_h, 10);
    chk("t4_v_active", cap_v, 3);
    chk("t4_fmt_err", cap_err, 1);
    chk("t4_line_end_with_frame_end", cap_le, 1);

    // Reset released in the middle of a frame
    vs = 1'b1;
    gap(3);
    send_line(0, HS); gap(4);
    send_line(1, HS); gap(4);
    de = 1'b1; hs = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    snap();
    rst = 1'b1;
    repeat (8) @(negedge clk);
    gap(4);
    send_line(3, HS); gap(4);
    send_line(4, HS); gap(4);
    vs = 1'b0;
    gap(8);
    chk("t5_no_frame_start", fs_cnt - b_fs, 0);
    chk("t5_no_pixels", pv_cnt - b_pv, 0);
    chk("t5_no_frame_end", fe_cnt - b_fe, 0);
    send_frame(VS, -1, 0, -1, 0);
    chk("t5_frame_start", fs_cnt - b_fs, 1);
    chk("t5_h_active", cap_h, HS);
    chk("t5_v_active", cap_v, VS);
    chk("t5_fmt_err", cap_err, 0);
    chk("t5_locked", cap_lock, 0);

`ifdef PATTERN_CHECK_EN
    inj_en = 1; inj_x = 10; inj_y = 3;
    send_frame(VS, -1, 0, -1, 0);
    inj_en = 0;
    chk("t6_mismatch_pulses", mm_cnt, 1);
    chk("t6_mismatch_x", mm_x, 10);
    chk("t6_mismatch_y", mm_y, 3);
    chk("t6_mismatch_cnt", mismatch_cnt, 1);
    chk("t6_fmt_err", cap_err, 1);
`endif

    chk("coord_errors", coord_err, 0);
    chk("data_errors", data_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dvi_rx_timing_monitor.md
Name: dvi_rx_timing_monitor

Overview:
Receive-side counterpart of the DVI pattern generator. It sits after the DVI RX core's parallel outputs in the pixel-clock domain and decodes the vs/hs/de/RGB stream into pixel coordinates, frame and line strobes, measured resolution, and a lock flag. It checks incoming timing against the expected active size, the same size the transmit side is built for.

Parameters:
HS_CNT_MAX, 16'd1920, expected de-high cycles per line
VS_CNT_MAX, 16'd1080, expected lines per frame
CNT_W, 16, width of all coordinate and measurement counters
LOCK_FRAMES, 2, consecutive good frames required to assert locked (range 1..15)

Ports:
clk  in  1  pixel clock (rgb clock of the RX core)
rst  in  1  asynchronous, active-low reset
vs  in  1  frame enable; high for the whole frame
hs  in  1  line sync; high with de during the active line
de  in  1  data enable
red / green / blue  in  8 each  pixel data
pix_valid  out  1  registered de, only inside a frame
pix_x / pix_y  out  CNT_W each  coordinates of the current pixel, 0-based
pix_r / pix_g / pix_b  out  8 each  pixel data aligned with pix_valid
frame_start  out  1  1-cycle pulse on vs rising edge
frame_end  out  1  1-cycle pulse on vs falling edge
line_end  out  1  1-cycle pulse on de falling edge inside a frame
h_active  out  CNT_W  de-high count of the last completed line
v_active  out  CNT_W  line count of the last completed frame
locked  out  1  timing stable and matches parameters
fmt_err  out  1  1-cycle pulse with frame_end when the frame was bad

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Input stage:
  - Stage s1 registers vs/hs/de/RGB.
  - Edges are detected from s1 against the previous s1 value.
  - The vs and de history registers reset to 1, so a frame already in progress at reset release is never captured.
- Latency: every output is registered from s1. Input to pix_valid/pix_* is 2 cycles; strobes follow the same 2-cycle alignment.
- Reset values:
  - All outputs 0, counters 0, lock counter 0.
  - State WAIT_VS.
- States:
  - WAIT_VS: ignore de. On a vs rising edge: frame_start=1, pix_y=0, line counter=0, frame_bad=0, go to WAIT_LINE.
  - WAIT_LINE: on a de rising edge, pix_x=0 and go to IN_LINE; that first pixel is presented with pix_x=0. On a vs falling edge, go to FRAME_DONE.
  - IN_LINE:
    - Each de-high cycle: pix_valid=1, and pix_x increments after the presented pixel. pix_x saturates at all-ones and sets frame_bad.
    - On a de falling edge: line_end=1, h_active=pixel count, line counter+1, pix_y+1, go to WAIT_LINE.
    - frame_bad is set if the count != HS_CNT_MAX or != the first line's count.
  - vs falls while in IN_LINE: the line is closed exactly as a de fall (line_end, h_active update, count), then FRAME_DONE in the same cycle.
  - FRAME_DONE (1 cycle):
    - frame_end=1; v_active=line count.
    - frame_bad is also set if the line count != VS_CNT_MAX.
    - fmt_err=frame_bad.
    - Go to WAIT_VS.
- de or hs activity while vs is low: no pix_valid, no strobes, and no effect on counters.
- hs is used only as a consistency check: hs != de inside a frame sets frame_bad.
- Lock:
  - The lock counter increments (saturating at LOCK_FRAMES) on each good frame_end.
  - Any bad frame clears the counter and deasserts locked in the FRAME_DONE cycle.
  - locked=1 when counter==LOCK_FRAMES.
- Zero-line frame: v_active=0, fmt_err=1.
- pix_y increments without saturating beyond the frame, but the line count saturates at all-ones and sets frame_bad.

Optional Feature:
PATTERN_CHECK_EN.
- Defined:
  - Adds parameters EXP_R/EXP_G/EXP_B (default 8'd255).
  - Adds output pix_mismatch (1, pulse aligned with pix_valid when pix_r/g/b != expected).
  - Adds output mismatch_cnt (CNT_W*2 bits, saturating, cleared on frame_start).
  - Any mismatch in a frame sets frame_bad.
- Undefined: no extra ports or logic; RGB is only passed through.

Test Plan:
1. Reset, then 3 frames of 1920 de cycles × 1080 lines, 40-cycle gaps, white RGB. Required: frame_start/frame_end once per frame, 1080 line_end pulses per frame, h_active=1920, v_active=1080, fmt_err=0, locked=1 after the 2nd frame_end.
2. Locked stream with one line of 1919 pixels in frame 4. Required: fmt_err=1 at frame_end, locked=0 in the same cycle, re-lock after 2 further good frames.
3. Assert vs for 1079 lines only. Required: v_active=1079, fmt_err=1. De pulses with vs low produce no pix_valid and no line_end.
4. Drop vs mid-line after 500 pixels. Required: line_end and frame_end in the same cycle, h_active=500, fmt_err=1.
5. Release reset with vs already high mid-frame. Required: no frame_start and no pix_valid until the next vs rising edge; the following complete frame is measured correctly.
6. With PATTERN_CHECK_EN defined, inject pixel (10,3)=8'h00 red. Required: pix_mismatch at pix_x=10, pix_y=3, mismatch_cnt=1, fmt_err=1.
